// File: rtl/i_cache.sv
`default_nettype none
// ==========================================================================
// i_cache : direct-mapped read-only instruction cache, byte-wide line refill.
//           Optional hit/miss statistics enabled by defining ICACHE_STAT_EN.
// Revision : 1.0
// ==========================================================================
module i_cache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           inst_o,
  output logic                  inst_valid_o,
  output logic                  stallreq_if,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_valid_i,
  input  logic [7:0]            mem_data_i
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem [LINES];
  logic [31:0]           data_mem [LINES];
  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [1:0]            cnt;
  logic [23:0]           line_buf;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  start_miss;
  logic                  byte_done;
  logic                  line_done;
  logic                  unused_addr_bits;

  assign index            = if_addr_i[INDEX_BITS+1:2];
  assign tag              = if_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_addr_bits = ^if_addr_i[1:0];
  assign hit              = valid[index] && (tag_mem[index] == tag);
  assign start_miss       = rst && (state == IDLE) && if_req_i && !hit;
  assign byte_done        = rst && (state == FETCH) && mem_valid_i;
  assign line_done        = byte_done && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are forced low while reset is held, whatever the current state.
  always_comb begin
    state_next   = state;
    inst_o       = 32'h0;
    inst_valid_o = 1'b0;
    stallreq_if  = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (if_req_i) begin
            if (hit) begin
              inst_o       = data_mem[index];
              inst_valid_o = 1'b1;
            end else begin
              stallreq_if = 1'b1;
              state_next  = FETCH;
            end
          end
        end
        FETCH: begin
          stallreq_if = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = {miss_tag, miss_index, cnt};
          if (mem_valid_i && (cnt == 2'd3)) begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid      <= '0;
      cnt        <= 2'd0;
      miss_tag   <= '0;
      miss_index <= '0;
      line_buf   <= 24'h0;
    end else if (start_miss) begin
      miss_tag   <= tag;
      miss_index <= index;
      cnt        <= 2'd0;
    end else if (byte_done) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    line_buf[7:0]   <= mem_data_i;
        2'd1:    line_buf[15:8]  <= mem_data_i;
        2'd2:    line_buf[23:16] <= mem_data_i;
        default: valid[miss_index] <= 1'b1;
      endcase
    end
  end

  // Line payload needs no reset: the valid bits alone gate every lookup.
  always_ff @(posedge clk) begin
    if (line_done) begin
      data_mem[miss_index] <= {mem_data_i, line_buf};
      tag_mem[miss_index]  <= miss_tag;
    end
  end

`ifdef ICACHE_STAT_EN
  logic        lookup_hit;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  assign lookup_hit = rst && (state == IDLE) && if_req_i && hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      if (lookup_hit) hit_cnt <= hit_cnt + 32'd1;
      if (start_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i_cache.sv
`default_nettype none
// ==========================================================================
// tb_i_cache : vector table, directed corner sequences and random traffic
//              against a word-level cache model. Revision : 1.0
// ==========================================================================
module tb_i_cache;
  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [7:0]  mem_data_i;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  i_cache dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_if  (stallreq_if),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_valid_i  (mem_valid_i),
    .mem_data_i   (mem_data_i)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Word-level reference: each line remembers which word address it holds.
  bit          m_v [128];
  logic [31:0] m_wa_line [128];
  bit          m_busy;
  logic [31:0] m_wa;
  int          m_got;
  int          m_hits;
  int          m_misses;
  int          resp_wait;

  logic [31:0] s_inst;
  logic        s_val, s_stall, s_mreq;
  logic [31:0] s_maddr;

  typedef struct {
    logic        r;
    logic        rq;
    logic [31:0] a;
    logic        mv;
    logic [7:0]  md;
    logic [31:0] e_inst;
    logic        e_val;
    logic        e_stall;
    logic        e_mreq;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] word_of(input logic [31:0] wa);
    if (wa == 32'h0) return 32'h00100513;
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] a);
    logic [31:0] w;
    w = word_of({2'b00, a[31:2]});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic vec_t mk(input logic r, input logic rq, input logic [31:0] a,
                              input logic mv, input logic [7:0] md,
                              input logic [31:0] ei, input logic ev, input logic es,
                              input logic em, input logic [31:0] ea);
    vec_t v;
    v.r = r; v.rq = rq; v.a = a; v.mv = mv; v.md = md;
    v.e_inst = ei; v.e_val = ev; v.e_stall = es; v.e_mreq = em; v.e_maddr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return m_v[a[8:2]] && (m_wa_line[a[8:2]] == (a >> 2));
  endfunction

  task automatic model_update(input logic r, input logic rq, input logic [31:0] a,
                              input logic mv);
    if (!r) begin
      for (int i = 0; i < 128; i++) m_v[i] = 1'b0;
      m_busy = 1'b0; m_hits = 0; m_misses = 0;
    end else if (m_busy) begin
      if (mv) begin
        m_got++;
        if (m_got == 4) begin
          m_v[m_wa[6:0]]       = 1'b1;
          m_wa_line[m_wa[6:0]] = m_wa;
          m_busy               = 1'b0;
        end
      end
    end else if (rq) begin
      if (model_hit(a)) begin
        m_hits++;
      end else begin
        m_busy = 1'b1; m_got = 0; m_wa = a >> 2; m_misses++;
      end
    end
  endtask

  // One clock: drive inputs, optionally play memory, compare with the model, advance.
  task automatic cycle(input logic r, input logic rq, input logic [31:0] a,
                       input logic mv, input logic [7:0] md, input bit auto_mem);
    logic [31:0] e_inst, e_maddr;
    logic        e_val, e_stall, e_mreq;
    rst = r; if_req_i = rq; if_addr_i = a; mem_valid_i = 1'b0; mem_data_i = 8'h0;
    #1;
    if (auto_mem) begin
      if (mem_req_o) begin
        if (resp_wait < 0) resp_wait = $urandom_range(0, 2);
        if (resp_wait == 0) begin
          mem_valid_i = 1'b1; mem_data_i = byte_of(mem_addr_o); resp_wait = -1;
        end else begin
          resp_wait--;
        end
      end else begin
        resp_wait = -1;
        if ($urandom_range(0, 7) == 0) begin
          mem_valid_i = 1'b1; mem_data_i = 8'($urandom);
        end
      end
    end else begin
      mem_valid_i = mv; mem_data_i = md;
    end
    #1;
    s_inst = inst_o; s_val = inst_valid_o; s_stall = stallreq_if;
    s_mreq = mem_req_o; s_maddr = mem_addr_o;
    e_inst = 32'h0; e_val = 1'b0; e_stall = 1'b0; e_mreq = 1'b0; e_maddr = 32'h0;
    if (r) begin
      if (m_busy) begin
        e_stall = 1'b1; e_mreq = 1'b1; e_maddr = (m_wa << 2) + 32'(m_got);
      end else if (rq) begin
        if (model_hit(a)) begin
          e_inst = word_of(a >> 2); e_val = 1'b1;
        end else begin
          e_stall = 1'b1;
        end
      end
    end
    chk("inst_o", s_inst, e_inst);
    chk("inst_valid_o", 32'(s_val), 32'(e_val));
    chk("stallreq_if", 32'(s_stall), 32'(e_stall));
    chk("mem_req_o", 32'(s_mreq), 32'(e_mreq));
    chk("mem_addr_o", s_maddr, e_maddr);
`ifdef ICACHE_STAT_EN
    chk("hit_cnt_o", hit_cnt_o, 32'(m_hits));
    chk("miss_cnt_o", miss_cnt_o, 32'(m_misses));
`endif
    @(posedge clk);
    model_update(r, rq, a, mem_valid_i);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0; mem_valid_i = 1'b0; mem_data_i = 8'h0;
    m_busy = 1'b0; m_got = 0; m_wa = 32'h0; m_hits = 0; m_misses = 0; resp_wait = -1;
    for (int i = 0; i < 128; i++) begin
      m_v[i] = 1'b0; m_wa_line[i] = 32'h0;
    end

    // Reset, cold miss of 0x0, repeat hit, conflict on 0x200 and eviction of 0x0.
    vecs.push_back(mk(0, 1, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0, 0, 8'h00, 32'h0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h13, 32'h0, 0, 1, 1, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h05, 32'h0, 0, 1, 1, 32'h1));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h10, 32'h0, 0, 1, 1, 32'h2));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h00, 32'h0, 0, 1, 1, 32'h3));
    vecs.push_back(mk(1, 1, 32'h0, 0, 8'h00, 32'h00100513, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0, 0, 8'h00, 32'h00100513, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h200, 0, 8'h00, 32'h0, 0, 1, 0, 32'h0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 1, 32'h200, 1, byte_of(32'h200 + k), 32'h0, 0, 1, 1, 32'h200 + k));
    vecs.push_back(mk(1, 1, 32'h200, 0, 8'h00, word_of(32'h80), 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0, 0, 8'h00, 32'h0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h13, 32'h0, 0, 1, 1, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h05, 32'h0, 0, 1, 1, 32'h1));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h10, 32'h0, 0, 1, 1, 32'h2));
    vecs.push_back(mk(1, 1, 32'h0, 1, 8'h00, 32'h0, 0, 1, 1, 32'h3));
    vecs.push_back(mk(1, 1, 32'h0, 0, 8'h00, 32'h00100513, 1, 0, 0, 32'h0));

    @(negedge clk);
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].rq, vecs[i].a, vecs[i].mv, vecs[i].md, 1'b0);
      chk($sformatf("vec%0d_inst", i), s_inst, vecs[i].e_inst);
      chk($sformatf("vec%0d_valid", i), 32'(s_val), 32'(vecs[i].e_val));
      chk($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_mreq", i), 32'(s_mreq), 32'(vecs[i].e_mreq));
      chk($sformatf("vec%0d_maddr", i), s_maddr, vecs[i].e_maddr);
    end
`ifdef ICACHE_STAT_EN
    chk("stat_miss_after_table", miss_cnt_o, 32'd3);
    chk("stat_hit_after_table", hit_cnt_o, 32'd4);
`endif

    // PC jumps from 0x10 to 0x40 after the first refill byte.
    cycle(1, 1, 32'h10, 0, 8'h00, 1'b0);
    chk("jump_miss_stall", 32'(s_stall), 32'd1);
    cycle(1, 1, 32'h10, 1, byte_of(32'h10), 1'b0);
    chk("jump_byte0_addr", s_maddr, 32'h10);
    for (int k = 1; k < 4; k++) begin
      cycle(1, 1, 32'h40, 1, byte_of(32'h10 + k), 1'b0);
      chk($sformatf("jump_byte%0d_addr", k), s_maddr, 32'h10 + k);
    end
    cycle(1, 1, 32'h40, 0, 8'h00, 1'b0);
    chk("jump_new_miss", 32'(s_stall), 32'd1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 32'h40, 1, byte_of(32'h40 + k), 1'b0);
    cycle(1, 1, 32'h40, 0, 8'h00, 1'b0);
    chk("jump_new_hit", 32'(s_val), 32'd1);
    cycle(1, 1, 32'h10, 0, 8'h00, 1'b0);
    chk("jump_old_line_valid", 32'(s_val), 32'd1);

    // Reset in the middle of a refill discards the partial line.
    cycle(1, 1, 32'h80, 0, 8'h00, 1'b0);
    cycle(1, 1, 32'h80, 1, byte_of(32'h80), 1'b0);
    cycle(1, 1, 32'h80, 1, byte_of(32'h81), 1'b0);
    cycle(0, 1, 32'h80, 1, byte_of(32'h82), 1'b0);
    chk("rst_mid_mreq", 32'(s_mreq), 32'd0);
`ifdef ICACHE_STAT_EN
    cycle(1, 0, 32'h0, 0, 8'h00, 1'b0);
    chk("stat_hit_cleared", hit_cnt_o, 32'd0);
    chk("stat_miss_cleared", miss_cnt_o, 32'd0);
`endif
    cycle(1, 1, 32'h80, 0, 8'h00, 1'b0);
    chk("rst_refetch_miss", 32'(s_stall), 32'd1);
    cycle(1, 1, 32'h80, 1, byte_of(32'h80), 1'b0);
    chk("rst_refetch_byte0", s_maddr, 32'h80);
    for (int k = 1; k < 4; k++) cycle(1, 1, 32'h80, 1, byte_of(32'h80 + k), 1'b0);
    cycle(1, 1, 32'h80, 0, 8'h00, 1'b0);
    chk("rst_refetch_hit", s_inst, word_of(32'h20));

    // Random traffic over a small address pool to force hits, conflicts and jumps.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic        r, rq;
      r  = ($urandom_range(0, 49) != 0);
      rq = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0)
        a = $urandom;
      else
        a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2)
            | 32'($urandom_range(0, 3));
      cycle(r, rq, a, 1'b0, 8'h00, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
